// File: rtl/bit_pack_buf.sv
// bit_pack_buf: packs NCH-bit channel beats into NCH*BEATS-bit words and queues them in a FWFT FIFO.
module bit_pack_buf #(
  parameter int NCH        = 16,
  parameter int BEATS      = 4,
  parameter int MSB_FIRST  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NCH-1:0]                  in_bits,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic                            flush,
  output logic [NCH*BEATS-1:0]            out_word,
  output logic [$clog2(BEATS):0]          out_beats,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [$clog2(FIFO_DEPTH):0]     level
);
  localparam int W  = NCH*BEATS;
  localparam int BW = $clog2(BEATS)+1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW+1;
  logic [BW-1:0] cnt_q, cnt_d, k;
  logic [W-1:0]  asm_q, asm_d, placed, push_word;
  logic          fp_q, fp_d;
  logic [W-1:0]  mem_q [FIFO_DEPTH];
  logic [BW-1:0] mbeats_q [FIFO_DEPTH];
  logic [PW-1:0] wp_q, rp_q;
  logic [LW-1:0] level_q;
  logic [BW-1:0] push_beats;
  logic [NCH-1:0] field;
  logic full, acc, last, ppush, push, pop;
  assign full     = level_q == LW'(FIFO_DEPTH);
  assign in_ready = !full || (cnt_q < BW'(BEATS-1) && !fp_q);
  assign acc      = in_valid && in_ready;
  assign ppush    = fp_q && !full;
  // a beat arriving alongside a partial-word push starts the next word
  assign k        = ppush ? '0 : cnt_q;
  assign last     = k == BW'(BEATS-1);
  assign push     = ppush || (acc && last);
  assign pop      = out_valid && out_ready;
  assign push_word  = ppush ? asm_q : asm_q | placed;
  assign push_beats = ppush ? cnt_q : BW'(BEATS);
  always_comb begin
    field = '0;
    for (int c = 0; c < NCH; c++) field[c] = (MSB_FIRST != 0) ? in_bits[NCH-1-c] : in_bits[c];
    placed = W'(field) << (NCH*((MSB_FIRST != 0) ? BEATS-1-int'(k) : int'(k)));
  end
  always_comb begin
    cnt_d = cnt_q;
    asm_d = asm_q;
    fp_d  = fp_q;
    if (ppush) begin
      cnt_d = '0;
      asm_d = '0;
      fp_d  = 1'b0;
    end
    if (acc) begin
      cnt_d = last ? '0 : k + 1'b1;
      asm_d = last ? '0 : (ppush ? '0 : asm_q) | placed;
    end
    if (flush && !fp_q && (acc ? !last : cnt_q != '0)) fp_d = 1'b1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      asm_q   <= '0;
      fp_q    <= 1'b0;
      wp_q    <= '0;
      rp_q    <= '0;
      level_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
      fp_q    <= fp_d;
      wp_q    <= push ? wp_q + 1'b1 : wp_q;
      rp_q    <= pop ? rp_q + 1'b1 : rp_q;
      level_q <= level_q + LW'(push) - LW'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wp_q]    <= push_word;
      mbeats_q[wp_q] <= push_beats;
    end
  end
  assign out_valid = level_q != '0;
  assign out_word  = out_valid ? mem_q[rp_q] : '0;
  assign out_beats = out_valid ? mbeats_q[rp_q] : '0;
  assign level     = level_q;
endmodule

// File: tb/tb_bit_pack_buf.sv
// tb_bit_pack_buf: scoreboard bench for LSB-first, MSB-first and legacy single-beat packers.
module tb_bit_pack_buf;
  typedef struct packed {logic [63:0] w; logic [2:0] b;} exp_t;
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;
  logic [15:0] d_bits = '0;
  logic d_valid = 1'b0, d_flush = 1'b0, d_oready = 1'b0;
  logic [63:0] m_word, s_word;
  logic [2:0] m_beats, s_beats, m_level, s_level;
  logic m_valid, s_valid, m_ir, s_ir;
  logic [15:0] l_bits = '0, l_word;
  logic l_valid = 1'b0, l_beats, l_ovalid, l_ir;
  logic [2:0] l_level;
  exp_t q_m[$], q_s[$], q_l[$];
  int tests = 0, fails = 0;
  logic [15:0] P [16] = '{16'h8001, 16'h4002, 16'h2004, 16'h1008, 16'h0810, 16'h0420, 16'h0240, 16'h0180,
                          16'hFFFF, 16'hC003, 16'h8181, 16'hA005, 16'h6006, 16'h3C3C, 16'h9009, 16'hE007};

  bit_pack_buf #(.NCH(16), .BEATS(4), .MSB_FIRST(0), .FIFO_DEPTH(4)) u_lsb (
    .clk(clk), .reset(reset), .in_bits(d_bits), .in_valid(d_valid), .in_ready(m_ir), .flush(d_flush),
    .out_word(m_word), .out_beats(m_beats), .out_valid(m_valid), .out_ready(d_oready), .level(m_level));
  bit_pack_buf #(.NCH(16), .BEATS(4), .MSB_FIRST(1), .FIFO_DEPTH(4)) u_msb (
    .clk(clk), .reset(reset), .in_bits(d_bits), .in_valid(d_valid), .in_ready(s_ir), .flush(d_flush),
    .out_word(s_word), .out_beats(s_beats), .out_valid(s_valid), .out_ready(d_oready), .level(s_level));
  bit_pack_buf #(.NCH(16), .BEATS(1), .MSB_FIRST(1), .FIFO_DEPTH(4)) u_leg (
    .clk(clk), .reset(reset), .in_bits(l_bits), .in_valid(l_valid), .in_ready(l_ir), .flush(1'b0),
    .out_word(l_word), .out_beats(l_beats), .out_valid(l_ovalid), .out_ready(1'b1), .level(l_level));

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  function automatic exp_t mk(input int base, input int nb, input bit msb);
    exp_t r;
    r.w = '0;
    r.b = 3'(nb);
    for (int k = 0; k < nb; k++) r.w |= 64'(P[(base+k)%16]) << (16*(msb ? 3-k : k));
    return r;
  endfunction

  task automatic expect_word(input int base, input int nb);
    q_m.push_back(mk(base, nb, 1'b0));
    q_s.push_back(mk(base, nb, 1'b1));
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [15:0] b);
    int n = 0;
    d_bits = b;
    d_valid = 1'b1;
    while (!m_ir && n < 100) begin cyc(1); n++; end
    if (n >= 100) chk("send_timeout", 64'(m_ir), 64'd1);
    cyc(1);
    d_valid = 1'b0;
  endtask

  task automatic send_run(input int base, input int nb);
    for (int k = 0; k < nb; k++) send(P[(base+k)%16]);
  endtask

  task automatic pulse_flush();
    d_flush = 1'b1;
    cyc(1);
    d_flush = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    d_oready = 1'b1;
    while ((m_level != 0 || s_level != 0) && n < 200) begin cyc(1); n++; end
    chk("drain_level", 64'(m_level), 64'd0);
  endtask

  always @(negedge clk) if (!reset && m_valid && d_oready) begin
    if (q_m.size() == 0) chk("lsb_unexpected_word", m_word, 64'hDEAD);
    else begin
      exp_t e;
      e = q_m.pop_front();
      chk("lsb_word", m_word, e.w);
      chk("lsb_beats", 64'(m_beats), 64'(e.b));
    end
  end

  always @(negedge clk) if (!reset && s_valid && d_oready) begin
    if (q_s.size() == 0) chk("msb_unexpected_word", s_word, 64'hDEAD);
    else begin
      exp_t e;
      e = q_s.pop_front();
      chk("msb_word", s_word, e.w);
      chk("msb_beats", 64'(s_beats), 64'(e.b));
    end
  end

  always @(negedge clk) if (!reset && l_ovalid) begin
    if (q_l.size() == 0) chk("leg_unexpected_word", 64'(l_word), 64'hDEAD);
    else begin
      exp_t e;
      e = q_l.pop_front();
      chk("leg_word", 64'(l_word), e.w);
      chk("leg_beats", 64'(l_beats), 64'(e.b));
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_valid", 64'(m_valid), 64'd0);
    chk("rst_word", m_word, 64'd0);
    chk("rst_beats", 64'(m_beats), 64'd0);
    chk("rst_level", 64'(m_level), 64'd0);
    chk("rst_in_ready", 64'(m_ir), 64'd1);
    d_oready = 1'b1;
    q_m.push_back('{64'h0008_0004_0002_0001, 3'd4});
    q_s.push_back('{64'h8000_4000_2000_1000, 3'd4});
    send(16'h0001); send(16'h0002); send(16'h0004); send(16'h0008);
    chk("latency_valid", 64'(m_valid), 64'd1);
    chk("latency_word", m_word, 64'h0008_0004_0002_0001);
    cyc(2);
    q_m.push_back('{64'h0000_0000_5555_AAAA, 3'd2});
    q_s.push_back('{64'h5555_AAAA_0000_0000, 3'd2});
    send(16'hAAAA); send(16'h5555);
    pulse_flush();
    cyc(4);
    pulse_flush();
    cyc(4);
    chk("empty_flush_level", 64'(m_level), 64'd0);
    chk("empty_flush_valid", 64'(m_valid), 64'd0);
    d_oready = 1'b0;
    for (int w = 0; w < 4; w++) begin
      expect_word(4*w, 4);
      send_run(4*w, 4);
    end
    chk("full_level", 64'(m_level), 64'd4);
    chk("full_in_ready_cnt0", 64'(m_ir), 64'd1);
    expect_word(16, 4);
    send_run(16, 3);
    chk("full_in_ready_cnt3", 64'(m_ir), 64'd0);
    chk("msb_in_ready_cnt3", 64'(s_ir), 64'd0);
    d_oready = 1'b1;
    cyc(1);
    d_oready = 1'b0;
    chk("after_pop_level", 64'(m_level), 64'd3);
    send(P[3]);
    chk("refill_level", 64'(m_level), 64'd4);
    expect_word(20, 2);
    send_run(20, 2);
    pulse_flush();
    chk("pending_in_ready", 64'(m_ir), 64'd0);
    cyc(3);
    chk("pending_hold_ready", 64'(m_ir), 64'd0);
    chk("pending_hold_level", 64'(m_level), 64'd4);
    d_oready = 1'b1;
    cyc(1);
    d_oready = 1'b0;
    cyc(2);
    chk("partial_pushed_level", 64'(m_level), 64'd4);
    chk("partial_pushed_ready", 64'(m_ir), 64'd1);
    drain();
    d_oready = 1'b0;
    for (int w = 0; w < 3; w++) begin
      expect_word(4*w+6, 4);
      send_run(4*w+6, 4);
    end
    send_run(2, 2);
    chk("pre_reset_level", 64'(m_level), 64'd3);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    q_m.delete();
    q_s.delete();
    chk("midrst_valid", 64'(m_valid), 64'd0);
    chk("midrst_level", 64'(m_level), 64'd0);
    chk("midrst_word", m_word, 64'd0);
    chk("midrst_msb_word", s_word, 64'd0);
    chk("midrst_beats", 64'(m_beats), 64'd0);
    chk("midrst_in_ready", 64'(m_ir), 64'd1);
    expect_word(9, 4);
    d_oready = 1'b1;
    send_run(9, 4);
    drain();
    q_l.push_back('{64'h8000, 3'd1});
    q_l.push_back('{64'hFF00, 3'd1});
    q_l.push_back('{64'h2C48, 3'd1});
    l_bits = 16'h0001;
    l_valid = 1'b1;
    chk("leg_in_ready", 64'(l_ir), 64'd1);
    cyc(1);
    chk("leg_valid", 64'(l_ovalid), 64'd1);
    chk("leg_first_word", 64'(l_word), 64'h8000);
    l_bits = 16'h00FF;
    cyc(1);
    l_bits = 16'h1234;
    cyc(1);
    l_valid = 1'b0;
    cyc(4);
    chk("leg_level_end", 64'(l_level), 64'd0);
    chk("lsb_queue_empty", 64'(q_m.size()), 64'd0);
    chk("msb_queue_empty", 64'(q_s.size()), 64'd0);
    chk("leg_queue_empty", 64'(q_l.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
